// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receiver (and a future oversampled transmitter).
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} rx_state_t;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;
endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clk tick at OVERSAMPLE x the baud rate.
module uart_baud_tick #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int DIV_RAW = clk_freq / (baud_rate * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CW'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampled UART receiver: synchronizer, start glitch rejection, mid-bit sampling,
// framing/parity/overrun detection, valid/ready delivery.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);
  logic            tick;
  logic [1:0]      sync_q;
  logic            rx_s;
  rx_state_t       state_q, state_d;
  logic [3:0]      os_q, os_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, ovr_q, ovr_d;
  logic            stop_tick, accept;

  uart_baud_tick #(.clk_freq(clk_freq), .baud_rate(baud_rate), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rx_s      = sync_q[1];
  assign stop_tick = tick && (state_q == STOP) && (os_q == 4'd15);
  assign accept    = valid_q && rx_ready;

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (tick) begin
      case (state_q)
        IDLE: if (!rx_s) begin
          os_d    = '0;
          par_d   = 1'b0;
          state_d = START;
        end
        START: if (os_q == 4'(MID_SAMPLE)) begin
          os_d    = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else os_d = os_q + 4'd1;
        DATA: if (os_q == 4'd15) begin
          os_d    = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'(DATA_BITS - 1)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          else                            bit_d   = bit_q + 3'd1;
        end else os_d = os_q + 4'd1;
        PARITY: if (os_q == 4'd15) begin
          os_d    = '0;
          par_d   = rx_s ^ (^shift_q) ^ (PARITY_ODD != 0);
          state_d = STOP;
        end else os_d = os_q + 4'd1;
        STOP: if (os_q == 4'd15) begin
          os_d    = '0;
          state_d = rx_s ? IDLE : BRK_WAIT;
        end else os_d = os_q + 4'd1;
        BRK_WAIT: if (rx_s) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A completion in the same clock as an accept takes priority over the clear.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    ovr_d   = ovr_q;
    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (stop_tick) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        fe_d    = !rx_s;
        pe_d    = par_q;
        valid_d = 1'b1;
      end else ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ovr_q   <= ovr_d;
    end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1 instance plus an even-parity instance, 160 clk per bit.
module tb_uart_rx_os;
  localparam int BIT_CLK = 160;

  logic clk = 1'b0, rst = 1'b0;
  logic rx = 1'b1, rx_ready = 1'b1, rx_p = 1'b1, ready_p = 1'b1;
  logic [7:0] rx_data, data_p;
  logic rx_valid, frame_err, parity_err, overrun, busy;
  logic valid_p, fe_p, pe_p, ovr_p, busy_p;

  int n_chk = 0, n_fail = 0;
  int n_vld = 0, n_byte = 0, n_byte_p = 0;
  int v0, b0;
  logic [7:0] cap_d = 8'h00, cap_d_p = 8'h00;
  logic cap_fe = 1'b0, cap_pe = 1'b0, cap_ov = 1'b0, cap_pe_p = 1'b0, cap_fe_p = 1'b0;
  logic busy_seen = 1'b0;

  always #5 clk = ~clk;

  uart_rx_os #(.clk_freq(1600000), .baud_rate(10000), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_os #(.clk_freq(1600000), .baud_rate(10000), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .rx_ready(ready_p), .rx_data(data_p), .rx_valid(valid_p),
    .frame_err(fe_p), .parity_err(pe_p), .overrun(ovr_p), .busy(busy_p)
  );

  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (rx_valid) begin
      n_vld++;
      if (rx_ready) begin
        n_byte++;
        cap_d  = rx_data;
        cap_fe = frame_err;
        cap_pe = parity_err;
        cap_ov = overrun;
      end
    end
    if (valid_p && ready_p) begin
      n_byte_p++;
      cap_d_p  = data_p;
      cap_pe_p = pe_p;
      cap_fe_p = fe_p;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Line is left at the stop level so a framing error can be extended into a break.
  task automatic send(input logic [7:0] d, input logic stop_b);
    rx = 1'b0; wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin rx = d[i]; wait_clk(BIT_CLK); end
    rx = stop_b; wait_clk(BIT_CLK);
  endtask

  task automatic send_p(input logic [7:0] d, input logic pbit);
    rx_p = 1'b0; wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin rx_p = d[i]; wait_clk(BIT_CLK); end
    rx_p = pbit; wait_clk(BIT_CLK);
    rx_p = 1'b1; wait_clk(BIT_CLK);
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_fe", 32'(frame_err), 0);
    chk("rst_pe", 32'(parity_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk) rst = 1'b1;
    wait_clk(50);

    // Plain 8N1 byte
    v0 = n_vld; b0 = n_byte;
    send(8'hA5, 1'b1); wait_clk(20);
    chk("a5_vld_cycles", 32'(n_vld - v0), 1);
    chk("a5_bytes", 32'(n_byte - b0), 1);
    chk("a5_data", 32'(cap_d), 32'hA5);
    chk("a5_fe", 32'(cap_fe), 0);
    chk("a5_pe", 32'(cap_pe), 0);
    chk("a5_ovr", 32'(cap_ov), 0);
    chk("a5_busy", 32'(busy), 0);

    // Start-bit glitch
    b0 = n_byte; busy_seen = 1'b0;
    rx = 1'b0; wait_clk(40); rx = 1'b1; wait_clk(200);
    chk("glitch_busy_seen", 32'(busy_seen), 1);
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_bytes", 32'(n_byte - b0), 0);
    send(8'h3C, 1'b1); wait_clk(20);
    chk("post_glitch_data", 32'(cap_d), 32'h3C);
    chk("post_glitch_bytes", 32'(n_byte - b0), 1);

    // Framing error followed by a held-low line
    b0 = n_byte;
    send(8'h3C, 1'b0); wait_clk(400);
    chk("fe_bytes", 32'(n_byte - b0), 1);
    chk("fe_data", 32'(cap_d), 32'h3C);
    chk("fe_flag", 32'(cap_fe), 1);
    chk("brk_busy", 32'(busy), 1);
    rx = 1'b1; wait_clk(320);
    chk("brk_release_busy", 32'(busy), 0);
    chk("brk_no_extra", 32'(n_byte - b0), 1);
    send(8'h55, 1'b1); wait_clk(20);
    chk("after_brk_data", 32'(cap_d), 32'h55);
    chk("after_brk_fe", 32'(cap_fe), 0);
    chk("after_brk_bytes", 32'(n_byte - b0), 2);

    // Overrun with the consumer stalled
    rx_ready = 1'b0;
    send(8'h11, 1'b1); send(8'h22, 1'b1); wait_clk(20);
    chk("ovr_valid", 32'(rx_valid), 1);
    chk("ovr_data", 32'(rx_data), 32'h11);
    chk("ovr_flag", 32'(overrun), 1);
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    #1;
    chk("ovr_acc_valid", 32'(rx_valid), 0);
    chk("ovr_acc_flag", 32'(overrun), 0);
    rx_ready = 1'b1;

    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    b0 = n_byte_p;
    send_p(8'h07, 1'b0); wait_clk(20);
    chk("par_bad_bytes", 32'(n_byte_p - b0), 1);
    chk("par_bad_data", 32'(cap_d_p), 32'h07);
    chk("par_bad_pe", 32'(cap_pe_p), 1);
    send_p(8'h07, 1'b1); wait_clk(20);
    chk("par_ok_pe", 32'(cap_pe_p), 0);
    chk("par_ok_fe", 32'(cap_fe_p), 0);
    send_p(8'hA5, 1'b0); wait_clk(20);
    chk("par_a5_data", 32'(cap_d_p), 32'hA5);
    chk("par_a5_pe", 32'(cap_pe_p), 0);
    chk("par_bytes", 32'(n_byte_p - b0), 3);

    // Reset in the middle of data bit 4 of 0xC3
    b0 = n_byte;
    rx = 1'b0; wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin rx = (8'hC3 >> i) & 8'h01; wait_clk(BIT_CLK); end
    rx = 1'b0; wait_clk(80);
    rst = 1'b0; rx = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(rx_valid), 0);
    chk("mid_rst_data", 32'(rx_data), 0);
    chk("mid_rst_fe", 32'(frame_err), 0);
    chk("mid_rst_pe", 32'(parity_err), 0);
    chk("mid_rst_ovr", 32'(overrun), 0);
    wait_clk(50);
    @(negedge clk) rst = 1'b1;
    wait_clk(50);
    chk("mid_rst_no_byte", 32'(n_byte - b0), 0);
    send(8'hFF, 1'b1); wait_clk(20);
    chk("ff_data", 32'(cap_d), 32'hFF);
    chk("ff_fe", 32'(cap_fe), 0);
    chk("ff_pe", 32'(cap_pe), 0);
    chk("ff_bytes", 32'(n_byte - b0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
